// File: rtl/game_overlord.sv
//------------------------------------------------------------------------------
// game_overlord: game-state sequencer (START/AIM/SHOOT/END), end-of-game timer,
// sprite strobes and a free-running 16-bit Galois LFSR random bit.
// Optional: define GAME_OVERLORD_SCORE_EN to add a saturating win counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module game_overlord #(
    parameter int unsigned TIMER_FRAMES = 128,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    input  logic       frame_tick,
    input  logic       collision,
    input  logic       sprite_target_out_of_screen,
    input  logic       sprite_torpedo_out_of_screen,
    output logic       sprite_target_write_xy,
    output logic       sprite_torpedo_write_xy,
    output logic       sprite_torpedo_write_dxy,
    output logic       sprite_target_enable_update,
    output logic       sprite_torpedo_enable_update,
    output logic       game_won,
    output logic       end_of_game_timer_running,
    output logic       random
`ifdef GAME_OVERLORD_SCORE_EN
    ,
    output logic [7:0] score
`endif
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_AIM   = 2'd1,
        ST_SHOOT = 2'd2,
        ST_END   = 2'd3
    } state_t;

    localparam logic [15:0] TIMER_LOAD = 16'(TIMER_FRAMES);
    localparam logic [15:0] LFSR_MASK  = 16'hB400;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        key_q;
    logic        tgt_wxy_q, tgt_wxy_d;
    logic        trp_wxy_q, trp_wxy_d;
    logic        trp_wdxy_q, trp_wdxy_d;
    logic        tgt_en_q, tgt_en_d;
    logic        trp_en_q, trp_en_d;
    logic        won_q, won_d;
    logic        run_q, run_d;
    logic        random_q, random_d;
    logic        key_rise;
    logic        enter_end;
`ifdef GAME_OVERLORD_SCORE_EN
    logic [7:0]  score_q, score_d;
`endif

    assign key_rise = key & ~key_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        tgt_wxy_d  = 1'b0;
        trp_wxy_d  = 1'b0;
        trp_wdxy_d = 1'b0;
        tgt_en_d   = tgt_en_q;
        trp_en_d   = trp_en_q;
        won_d      = won_q;
        run_d      = run_q;
        enter_end  = 1'b0;
`ifdef GAME_OVERLORD_SCORE_EN
        score_d    = score_q;
`endif
        // Shifts every cycle regardless of game state; a nonzero seed never reaches zero.
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        random_d = lfsr_d[0];

        case (state_q)
            ST_START: begin
                tgt_wxy_d = 1'b1;
                trp_wxy_d = 1'b1;
                won_d     = 1'b0;
                tgt_en_d  = 1'b1;
                trp_en_d  = 1'b0;
                run_d     = 1'b0;
                state_d   = ST_AIM;
            end
            ST_AIM: begin
                if (sprite_target_out_of_screen) begin
                    won_d     = 1'b0;
                    enter_end = 1'b1;
                end else if (key_rise) begin
                    trp_wdxy_d = 1'b1;
                    tgt_en_d   = 1'b1;
                    trp_en_d   = 1'b1;
                    state_d    = ST_SHOOT;
                end
            end
            ST_SHOOT: begin
                if (collision) begin
                    won_d     = 1'b1;
                    enter_end = 1'b1;
`ifdef GAME_OVERLORD_SCORE_EN
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
`endif
                end else if (sprite_target_out_of_screen || sprite_torpedo_out_of_screen) begin
                    won_d     = 1'b0;
                    enter_end = 1'b1;
                end
            end
            default: begin
                if (frame_tick) begin
                    if (timer_q <= 16'd1) begin
                        timer_d = 16'd0;
                        run_d   = 1'b0;
                        won_d   = 1'b0;
                        state_d = ST_START;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
            end
        endcase

        if (enter_end) begin
            state_d  = ST_END;
            tgt_en_d = 1'b0;
            trp_en_d = 1'b0;
            run_d    = 1'b1;
            timer_d  = TIMER_LOAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_START;
            timer_q    <= 16'd0;
            lfsr_q     <= LFSR_SEED;
            key_q      <= 1'b0;
            tgt_wxy_q  <= 1'b0;
            trp_wxy_q  <= 1'b0;
            trp_wdxy_q <= 1'b0;
            tgt_en_q   <= 1'b0;
            trp_en_q   <= 1'b0;
            won_q      <= 1'b0;
            run_q      <= 1'b0;
            random_q   <= 1'b0;
`ifdef GAME_OVERLORD_SCORE_EN
            score_q    <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            lfsr_q     <= lfsr_d;
            key_q      <= key;
            tgt_wxy_q  <= tgt_wxy_d;
            trp_wxy_q  <= trp_wxy_d;
            trp_wdxy_q <= trp_wdxy_d;
            tgt_en_q   <= tgt_en_d;
            trp_en_q   <= trp_en_d;
            won_q      <= won_d;
            run_q      <= run_d;
            random_q   <= random_d;
`ifdef GAME_OVERLORD_SCORE_EN
            score_q    <= score_d;
`endif
        end
    end

    assign sprite_target_write_xy       = tgt_wxy_q;
    assign sprite_torpedo_write_xy      = trp_wxy_q;
    assign sprite_torpedo_write_dxy     = trp_wdxy_q;
    assign sprite_target_enable_update  = tgt_en_q;
    assign sprite_torpedo_enable_update = trp_en_q;
    assign game_won                     = won_q;
    assign end_of_game_timer_running    = run_q;
    assign random                       = random_q;
`ifdef GAME_OVERLORD_SCORE_EN
    assign score                        = score_q;
`endif

endmodule

`default_nettype wire

// File: doc/game_overlord.md
Name: game_overlord

Overview:
- Game-state sequencer that drives the mixer-side status signals: game_won, end_of_game_timer_running and random.
- Also drives sprite control strobes for the target and torpedo sprites.
- Consumes collision/out-of-screen events and a per-frame tick from the display timing block, plus the launch key.
- Sits between the sprite engines and the RGB mixer; owns the win/lose decision and the end-of-game display timer.

Parameters:
TIMER_FRAMES, 128, number of frame_tick pulses the end-of-game screen lasts (1..65535)
LFSR_SEED, 16'hACE1, reset value of the 16-bit random LFSR; must be nonzero

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
key  input  1  launch button, already synchronised to clk, level
frame_tick  input  1  one-cycle pulse once per frame (start of vertical blank)
collision  input  1  torpedo/target overlap this cycle, level
sprite_target_out_of_screen  input  1  target has left visible area, level
sprite_torpedo_out_of_screen  input  1  torpedo has left visible area, level
sprite_target_write_xy  output  1  one-cycle pulse: target loads start position
sprite_torpedo_write_xy  output  1  one-cycle pulse: torpedo loads start position
sprite_torpedo_write_dxy  output  1  one-cycle pulse: torpedo loads launch velocity
sprite_target_enable_update  output  1  level: target may move
sprite_torpedo_enable_update  output  1  level: torpedo may move
game_won  output  1  result of last game; valid while end_of_game_timer_running
end_of_game_timer_running  output  1  end-of-game screen active
random  output  1  pseudo-random bit, new value every clk

Behaviour:
- All outputs are registered. Reset value of every output is 0. LFSR reset value is LFSR_SEED. State resets to START.
- key_rise = key & ~key_q, where key_q is a registered copy of key (reset 0).
- START: pulse sprite_target_write_xy and sprite_torpedo_write_xy for exactly 1 cycle, clear game_won, then go to AIM.
- AIM:
  - sprite_target_enable_update=1, sprite_torpedo_enable_update=0.
  - sprite_target_out_of_screen -> game_won=0, go to END.
  - Else key_rise -> pulse sprite_torpedo_write_dxy for 1 cycle, go to SHOOT.
  - Out-of-screen has priority over key_rise in the same cycle.
- SHOOT:
  - Both enable_update=1.
  - Priority: collision -> game_won=1, go to END. Else either out_of_screen -> game_won=0, go to END.
  - key is ignored in SHOOT.
- END:
  - Both enable_update=0; end_of_game_timer_running=1 from the first END cycle.
  - Timer (16-bit) is loaded with TIMER_FRAMES on entry and decrements on each frame_tick.
  - frame_tick with timer==1 -> next cycle state START, timer_running=0.
  - END therefore spans exactly TIMER_FRAMES frame_ticks.
  - game_won is held stable throughout END and cleared in START.
  - collision, out-of-screen and key are all ignored in END.
- Output timing: registered outputs change on the clock edge that enters a state, so all status outputs are coincident with the state register. Pulses are never longer than 1 cycle.
- random = lfsr[0]. The LFSR is a 16-bit Galois LFSR with taps 16,14,13,11 (mask 16'hB400) and shifts every clk, independent of state. It never reaches the all-zero state.
- Reset mid-game: asynchronously returns to START, all outputs 0, timer 0. The START pulses occur on the first clk after reset deasserts.

Optional Feature:
- Macro GAME_OVERLORD_SCORE_EN.
- Defined:
  - Adds output port score [7:0], reset 0.
  - score increments by 1 on each transition SHOOT->END with game_won=1.
  - Saturates at 255.
  - Unchanged by losses.
- Undefined: the score port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset release -> sprite_target_write_xy=1 and sprite_torpedo_write_xy=1 on exactly one cycle; then target_enable_update=1, torpedo_enable_update=0; all else 0.
- In AIM, key held high for 5 cycles -> exactly one sprite_torpedo_write_dxy pulse; torpedo_enable_update=1 next cycle. Second key press in SHOOT -> no pulse.
- In SHOOT, collision=1 and sprite_torpedo_out_of_screen=1 in the same cycle -> game_won=1, end_of_game_timer_running=1. With TIMER_FRAMES=4, running stays 1 for exactly 4 frame_ticks, then START pulses recur.
- In AIM, sprite_target_out_of_screen=1 -> game_won=0, timer_running=1; key presses during END -> no write_dxy.
- Random: after reset with seed 16'hACE1, the first 16 random bits match the Galois model. Over 65535 cycles the LFSR never reaches 0 and returns to the seed at period 65535.
- With GAME_OVERLORD_SCORE_EN: 3 wins and 2 losses -> score=3. 300 forced wins -> score=255. Reset -> 0.
